uart_rx_8e1: RTL and testbench

- Serial receiver for our 8-data-bit, even-parity, 1-stop-bit UART frame, LSB first, idle-high line.
- Frame on the wire: start(0), d0..d7, parity (= XOR of d7..d0), stop(1).
- Oversamples the asynchronous line with the system clock and recovers each byte.
- Presents the byte with a one-cycle valid strobe plus parity/framing error flags to downstream logic (FIFO or register file).

---
 rtl/uart_rx_8e1.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_8e1.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_8e1.sv
// uart_rx_8e1 -- 8 data bits, even parity, 1 stop bit UART receiver.
//
// Frame on the wire (LSB first, idle high):
//   start(0), d0..d7, parity (= ^d7..d0), stop(1)
//
// The line is oversampled by the system clock (OVERSAMPLE clk per bit).
// Each bit is sampled at its middle, which is found by timing half a bit
// from the start-bit edge. Bytes with parity or framing errors are still
// delivered, with the error flags set.
//
// Ports:
//   clk         system clock, OVERSAMPLE x baud rate
//   rst_n       asynchronous active-low reset
//   line        asynchronous serial input, idle high
//   data        received byte, held until the next frame completes
//   valid       one-cycle pulse when data/parity_err/frame_err update
//   parity_err  received parity bit differs from ^data (held like data)
//   frame_err   stop bit sampled low (held like data)
//   busy        high whenever the receiver is not idle
`timescale 1ns/1ps

module uart_rx_8e1 #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  // Mid start bit is reached half a bit after the first low sample; every
  // later sample is a full bit period after the previous one.
  localparam logic [CNT_W-1:0] TICK_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] TICK_FULL = CNT_W'(OVERSAMPLE - 1);

  logic             sync1_q;
  logic             rx_s_q;
  logic [2:0]       state_q,  state_d;
  logic [CNT_W-1:0] tick_q,   tick_d;
  logic [2:0]       bit_q,    bit_d;
  logic [7:0]       shift_q,  shift_d;
  logic             par_q,    par_d;
  logic [7:0]       data_q,   data_d;
  logic             valid_q,  valid_d;
  logic             perr_q,   perr_d;
  logic             ferr_q,   ferr_d;

  // Two-flop synchronizer; nothing downstream looks at the raw line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= line;
      rx_s_q  <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        // Level detect: a start bit straight after a stop bit is accepted.
        if (!rx_s_q) state_d = S_START;
      end

      S_START: begin
        if (tick_q == TICK_HALF) begin
          tick_d = '0;
          bit_d  = '0;
          // High at mid start bit means the low level was only a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (tick_q == TICK_FULL) begin
          tick_d  = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_PARITY;
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end

      S_PARITY: begin
        if (tick_q == TICK_FULL) begin
          tick_d  = '0;
          par_d   = rx_s_q;
          state_d = S_STOP;
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (tick_q == TICK_FULL) begin
          tick_d  = '0;
          valid_d = 1'b1;
          data_d  = shift_q;
          perr_d  = (^shift_q) ^ par_q;
          ferr_d  = ~rx_s_q;
          // A low stop bit may be a break; wait for the line to recover
          // before looking for another start bit.
          state_d = rx_s_q ? S_IDLE : S_BREAK;
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end

      S_BREAK: begin
        tick_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_8e1.sv
`timescale 1ns/1ps

module tb_uart_rx_8e1;

  localparam int OS = 16;

  logic       clk;
  logic       rst_n;
  logic       line;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  int cyc           = 0;
  int vld_count     = 0;
  int last_vld_cyc  = 0;
  int prev_vld_cyc  = 0;
  logic [7:0] last_vld_data = 8'h00;
  logic [7:0] prev_vld_data = 8'h00;
  int fall_cyc      = 0;

  uart_rx_8e1 #(.OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line       (line),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      vld_count     <= vld_count + 1;
      prev_vld_cyc  <= last_vld_cyc;
      last_vld_cyc  <= cyc;
      prev_vld_data <= last_vld_data;
      last_vld_data <= data;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one complete frame, 16 clk per bit, starting right away.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    logic [10:0] bits;
    bits = {stp, par, b, 1'b0};
    fall_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      line = bits[i];
      step(OS);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    line  = 1'b1;
    step(3);
    compared++;
    if ({data, valid, parity_err, frame_err, busy} !== 12'h000) begin
      mismatched++;
      $display("FAIL reset_outputs: got data=%h v=%b pe=%b fe=%b busy=%b, want all zero",
               data, valid, parity_err, frame_err, busy);
    end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_idle();
    int v0;
    v0 = vld_count;
    for (int i = 0; i < 100; i++) begin
      step(1);
      compared++;
      if (valid !== 1'b0 || busy !== 1'b0 || data !== 8'h00) begin
        mismatched++;
        $display("FAIL idle_cycle%0d: got v=%b busy=%b data=%h, want v=0 busy=0 data=00",
                 i, valid, busy, data);
      end
    end
    compared++;
    if (vld_count !== v0) begin
      mismatched++;
      $display("FAIL idle_valid_count: got %0d, want %0d", vld_count, v0);
    end
  endtask

  task automatic test_good_frame();
    int v0;
    v0 = vld_count;
    send_frame(8'hA5, 1'b0, 1'b1);
    line = 1'b1;
    step(4);
    compared++;
    if (vld_count !== v0 + 1) begin
      mismatched++;
      $display("FAIL a5_pulse_count: got %0d, want %0d", vld_count - v0, 1);
    end
    compared++;
    if (last_vld_cyc - fall_cyc !== 171) begin
      mismatched++;
      $display("FAIL a5_latency: got %0d, want 171", last_vld_cyc - fall_cyc);
    end
    compared++;
    if (data !== 8'hA5 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL a5_result: got data=%h pe=%b fe=%b, want A5 0 0",
               data, parity_err, frame_err);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL a5_busy_after: got %b, want 0", busy);
    end
  endtask

  task automatic test_parity_err();
    int v0;
    v0 = vld_count;
    send_frame(8'h01, 1'b0, 1'b1);
    line = 1'b1;
    step(4);
    compared++;
    if (vld_count !== v0 + 1 || data !== 8'h01 || parity_err !== 1'b1 || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL parity_err: got n=%0d data=%h pe=%b fe=%b, want n=1 data=01 pe=1 fe=0",
               vld_count - v0, data, parity_err, frame_err);
    end
  endtask

  task automatic test_break();
    int v0;
    v0 = vld_count;
    send_frame(8'h3C, 1'b0, 1'b0);
    step(40);
    compared++;
    if (vld_count !== v0 + 1 || data !== 8'h3C || frame_err !== 1'b1 || parity_err !== 1'b0) begin
      mismatched++;
      $display("FAIL break_result: got n=%0d data=%h pe=%b fe=%b, want n=1 data=3C pe=0 fe=1",
               vld_count - v0, data, parity_err, frame_err);
    end
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL break_busy_low_line: got %b, want 1", busy);
    end
    line = 1'b1;
    step(2);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL break_busy_sync_delay: got %b, want 1", busy);
    end
    step(1);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL break_busy_release: got %b, want 0", busy);
    end
    compared++;
    if (vld_count !== v0 + 1) begin
      mismatched++;
      $display("FAIL break_extra_valid: got %0d pulses, want 1", vld_count - v0);
    end
  endtask

  task automatic test_glitch();
    int v0;
    v0 = vld_count;
    line = 1'b0;
    step(4);
    line = 1'b1;
    step(6);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL glitch_busy_before_check: got %b, want 1", busy);
    end
    step(1);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL glitch_busy_after_check: got %b, want 0", busy);
    end
    step(20);
    compared++;
    if (vld_count !== v0 || data !== 8'h3C || frame_err !== 1'b1 || parity_err !== 1'b0) begin
      mismatched++;
      $display("FAIL glitch_no_effect: got n=%0d data=%h pe=%b fe=%b, want n=0 data=3C pe=0 fe=1",
               vld_count - v0, data, parity_err, frame_err);
    end
    send_frame(8'h5A, 1'b0, 1'b1);
    line = 1'b1;
    step(4);
    compared++;
    if (vld_count !== v0 + 1 || data !== 8'h5A || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL glitch_next_frame: got n=%0d data=%h pe=%b fe=%b, want n=1 data=5A pe=0 fe=0",
               vld_count - v0, data, parity_err, frame_err);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = vld_count;
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1);
    line = 1'b1;
    step(4);
    compared++;
    if (vld_count !== v0 + 2) begin
      mismatched++;
      $display("FAIL b2b_pulse_count: got %0d, want 2", vld_count - v0);
    end
    compared++;
    if (last_vld_cyc - prev_vld_cyc !== 176) begin
      mismatched++;
      $display("FAIL b2b_spacing: got %0d, want 176", last_vld_cyc - prev_vld_cyc);
    end
    compared++;
    if (prev_vld_data !== 8'hFF || data !== 8'h00 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_data: got first=%h second=%h pe=%b fe=%b, want FF 00 0 0",
               prev_vld_data, data, parity_err, frame_err);
    end

    // Third frame 0x96, interrupted by reset in the middle of d3.
    v0 = vld_count;
    line = 1'b0;       // start
    step(OS);
    line = 1'b0;       // d0
    step(OS);
    line = 1'b1;       // d1
    step(OS);
    line = 1'b1;       // d2
    step(OS);
    line = 1'b0;       // d3
    step(OS / 2);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_midframe_busy_before: got %b, want 1", busy);
    end
    rst_n = 1'b0;
    #2;
    compared++;
    if ({data, valid, parity_err, frame_err, busy} !== 12'h000) begin
      mismatched++;
      $display("FAIL reset_midframe_outputs: got data=%h v=%b pe=%b fe=%b busy=%b, want all zero",
               data, valid, parity_err, frame_err, busy);
    end
    step(2);
    line = 1'b1;
    rst_n = 1'b1;
    step(200);
    compared++;
    if (vld_count !== v0 || busy !== 1'b0 || data !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_midframe_no_valid: got n=%0d busy=%b data=%h, want n=0 busy=0 data=00",
               vld_count - v0, busy, data);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    line  = 1'b1;
    test_reset();
    test_idle();
    test_good_frame();
    test_parity_err();
    test_break();
    test_glitch();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
